// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: shared state encoding and width constants for the run controller
package cpu_run_ctrl_pkg;
  localparam int IMEM_AW_D = 9;
  localparam int DMEM_AW_D = 10;
  localparam int DATA_W_D = 32;
  localparam int CYC_W_D = 16;
  localparam int LOAD_CW_D = IMEM_AW_D + 1;
  localparam int DUMP_CW_D = DMEM_AW_D + 1;
  localparam int WORD_BYTES = 4;
  typedef logic [2:0] state_t;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN = 3'd2;
  localparam logic [2:0] S_DUMP_RD = 3'd3;
  localparam logic [2:0] S_DUMP_WAIT = 3'd4;
  localparam logic [2:0] S_DUMP_OUT = 3'd5;
  localparam logic [2:0] S_FIN = 3'd6;
endpackage

// File: rtl/ctrl_down_counter.sv
// ctrl_down_counter: loadable down counter with zero and last-count flags
module ctrl_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         ld,
  input  logic         dec,
  input  logic [W-1:0] din,
  output logic         zero,
  output logic         last
);
  logic [W-1:0] cnt;
  // load wins over decrement; decrement saturates at zero
  always_ff @(posedge clk or posedge arst)
    if (arst) cnt <= '0;
    else if (ld) cnt <= din;
    else if (dec && !zero) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
  assign last = cnt == W'(1);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: loads a program, runs the CPU for a set cycle count, then dumps data memory
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_D,
  parameter int DMEM_AW = DMEM_AW_D,
  parameter int DATA_W = DATA_W_D,
  parameter int CYC_W = CYC_W_D
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              start,
  input  logic              abort,
  input  logic [IMEM_AW:0]  load_words,
  input  logic [CYC_W-1:0]  run_cycles,
  input  logic [DATA_W-1:0] dump_base,
  input  logic [DMEM_AW:0]  dump_words,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              cpu_arst_n,
  output logic              cpu_enable,
  output logic [DATA_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [DATA_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              busy,
  output logic              done
);
  state_t state, state_nx, after_run, after_load, from_idle;
  logic idle_go, load_hs, dump_hs;
  logic load_zero, load_last_unused, run_zero, run_last, dump_zero, dump_last;
  logic [DATA_W-1:0] ld_addr, dp_addr;
  assign idle_go = state == S_IDLE && start;
  assign s_ready = state == S_LOAD && !load_zero;
  assign load_hs = s_valid && s_ready;
  assign m_valid = state == S_DUMP_OUT;
  assign dump_hs = m_valid && m_ready;
  assign cpu_enable = state == S_RUN;
  assign ren_ext_2 = state == S_DUMP_RD;
  assign addr_ext_2 = dp_addr;
  assign wen_ext_2 = 1'b0;
  assign wdata_ext_2 = '0;
  assign ren_ext = 1'b0;
  assign busy = state != S_IDLE;
  assign done = state == S_FIN;
  ctrl_down_counter #(.W(IMEM_AW + 1)) u_load_cnt (
    .clk(clk), .arst(arst), .ld(idle_go), .dec(load_hs), .din(load_words),
    .zero(load_zero), .last(load_last_unused)
  );
  ctrl_down_counter #(.W(CYC_W)) u_run_cnt (
    .clk(clk), .arst(arst), .ld(idle_go), .dec(cpu_enable), .din(run_cycles),
    .zero(run_zero), .last(run_last)
  );
  ctrl_down_counter #(.W(DMEM_AW + 1)) u_dump_cnt (
    .clk(clk), .arst(arst), .ld(idle_go), .dec(dump_hs), .din(dump_words),
    .zero(dump_zero), .last(dump_last)
  );
  // next state: phases with a zero count are skipped; abort overrides everything
  always_comb begin
    after_run = dump_zero ? S_FIN : S_DUMP_RD;
    after_load = run_zero ? after_run : S_RUN;
    from_idle = load_words != '0 ? S_LOAD : run_cycles != '0 ? S_RUN :
                dump_words != '0 ? S_DUMP_RD : S_FIN;
    state_nx = abort ? S_IDLE :
               state == S_IDLE ? (start ? from_idle : S_IDLE) :
               state == S_LOAD ? (load_zero ? after_load : S_LOAD) :
               state == S_RUN ? (run_last ? after_run : S_RUN) :
               state == S_DUMP_RD ? S_DUMP_WAIT :
               state == S_DUMP_WAIT ? S_DUMP_OUT :
               state == S_DUMP_OUT ? (m_ready ? (dump_last ? S_FIN : S_DUMP_RD) : S_DUMP_OUT) :
               S_IDLE;
  end
  // state register; CPU reset is released from the first RUN-or-later cycle
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      state <= S_IDLE;
      cpu_arst_n <= 1'b0;
    end else begin
      state <= state_nx;
      cpu_arst_n <= !(state_nx == S_IDLE || state_nx == S_LOAD);
    end
  // load write path: each accepted word becomes a registered write one cycle later
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      wen_ext <= 1'b0;
      addr_ext <= '0;
      wdata_ext <= '0;
      ld_addr <= '0;
    end else begin
      wen_ext <= load_hs && !abort;
      if (idle_go) ld_addr <= '0;
      else if (load_hs) begin
        ld_addr <= ld_addr + DATA_W'(WORD_BYTES);
        addr_ext <= ld_addr;
        wdata_ext <= s_data;
      end
    end
  // dump path: read address walks from dump_base, read data captured after one cycle
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      dp_addr <= '0;
      m_data <= '0;
    end else begin
      if (idle_go) dp_addr <= dump_base;
      else if (dump_hs) dp_addr <= dp_addr + DATA_W'(WORD_BYTES);
      if (state == S_DUMP_WAIT) m_data <= rdata_ext_2;
    end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for the run controller
module tb_cpu_run_ctrl;
  logic clk = 0, arst = 0, start = 0, abort = 0, s_valid = 0, m_ready = 0;
  logic [9:0] load_words = '0;
  logic [15:0] run_cycles = '0;
  logic [31:0] dump_base = '0, s_data = '0, rdata_ext_2 = '0;
  logic [10:0] dump_words = '0;
  logic s_ready, m_valid, cpu_arst_n, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2, busy, done;
  logic [31:0] m_data, addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  int n_chk = 0, n_pass = 0, done_cnt = 0, en_cnt;

  cpu_run_ctrl dut (
    .clk(clk), .arst(arst), .start(start), .abort(abort), .load_words(load_words),
    .run_cycles(run_cycles), .dump_base(dump_base), .dump_words(dump_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ren_ext_2) rdata_ext_2 <= addr_ext_2 ^ 32'h5A5A0000;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cmd(input logic [9:0] lw, input logic [15:0] rc, input logic [31:0] db, input logic [10:0] dw);
    start = 1;
    load_words = lw;
    run_cycles = rc;
    dump_base = db;
    dump_words = dw;
  endtask

  initial begin
    #1 arst = 1;
    #1;
    chk("rst_busy", busy, 0); chk("rst_arst_n", cpu_arst_n, 0); chk("rst_enable", cpu_enable, 0);
    chk("rst_s_ready", s_ready, 0); chk("rst_m_valid", m_valid, 0); chk("rst_done", done, 0);
    chk("rst_wen", wen_ext, 0); chk("rst_addr", addr_ext, 0); chk("rst_ren2", ren_ext_2, 0);
    chk("rst_addr2", addr_ext_2, 0); chk("rst_ren", ren_ext, 0); chk("rst_wdata2", wdata_ext_2, 0);
    @(posedge clk); #1 arst = 0;
    // program load, run and dump with back-pressure
    cmd(3, 10, 32'h40, 2); s_valid = 1; s_data = 32'h20010005;
    step;
    chk("ld_busy", busy, 1); chk("ld_s_ready", s_ready, 1); chk("ld_arst_n", cpu_arst_n, 0); chk("ld_wen0", wen_ext, 0);
    start = 0;
    step;
    chk("w0_wen", wen_ext, 1); chk("w0_addr", addr_ext, 32'h0); chk("w0_data", wdata_ext, 32'h20010005);
    s_data = 32'h20020007;
    step;
    chk("w1_wen", wen_ext, 1); chk("w1_addr", addr_ext, 32'h4); chk("w1_data", wdata_ext, 32'h20020007);
    s_data = 32'h00221820;
    step;
    chk("w2_wen", wen_ext, 1); chk("w2_addr", addr_ext, 32'h8); chk("w2_data", wdata_ext, 32'h00221820);
    chk("w2_s_ready", s_ready, 0); chk("w2_enable", cpu_enable, 0); chk("w2_arst_n", cpu_arst_n, 0);
    s_valid = 0;
    step;
    chk("run_enable", cpu_enable, 1); chk("run_arst_n", cpu_arst_n, 1); chk("run_wen", wen_ext, 0);
    en_cnt = 0;
    for (int i = 0; i < 20 && cpu_enable; i++) begin
      en_cnt++;
      step;
    end
    chk("run_len", en_cnt, 10);
    chk("rd0_ren2", ren_ext_2, 1); chk("rd0_addr2", addr_ext_2, 32'h40); chk("rd0_arst_n", cpu_arst_n, 1);
    step;
    chk("wait_m_valid", m_valid, 0); chk("wait_ren2", ren_ext_2, 0);
    step;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", m_valid, 1); chk("stall_data", m_data, 32'h5A5A0040);
      step;
    end
    chk("out0_valid", m_valid, 1); chk("out0_data", m_data, 32'h5A5A0040);
    m_ready = 1;
    step;
    chk("rd1_ren2", ren_ext_2, 1); chk("rd1_addr2", addr_ext_2, 32'h44); chk("rd1_m_valid", m_valid, 0);
    m_ready = 0;
    step; step;
    chk("out1_valid", m_valid, 1); chk("out1_data", m_data, 32'h5A5A0044);
    m_ready = 1;
    step;
    chk("fin_done", done, 1); chk("fin_arst_n", cpu_arst_n, 1); chk("fin_m_valid", m_valid, 0);
    m_ready = 0; start = 1;
    step;
    chk("idle_done", done, 0); chk("idle_busy", busy, 0); chk("idle_arst_n", cpu_arst_n, 0);
    start = 0;
    step;
    chk("start_at_fin_ignored", busy, 0); chk("done_cnt1", done_cnt, 1);
    // all counts zero
    cmd(0, 0, 0, 0);
    step;
    chk("z_done", done, 1); chk("z_busy", busy, 1); chk("z_wen", wen_ext, 0);
    chk("z_ren2", ren_ext_2, 0); chk("z_s_ready", s_ready, 0); chk("z_enable", cpu_enable, 0);
    start = 0;
    step;
    chk("z_idle_done", done, 0); chk("z_idle_busy", busy, 0); chk("done_cnt2", done_cnt, 2);
    // abort together with start in IDLE
    cmd(1, 1, 0, 1); abort = 1;
    step;
    chk("abort_start_busy", busy, 0);
    start = 0; abort = 0;
    step;
    chk("abort_start_idle", busy, 0);
    // abort mid-load
    cmd(4, 2, 32'h100, 1); s_valid = 1; s_data = 32'h11111111;
    step;
    start = 0;
    chk("ab_s_ready", s_ready, 1);
    step;
    chk("ab_wen", wen_ext, 1); chk("ab_addr", addr_ext, 0); chk("ab_data", wdata_ext, 32'h11111111);
    s_data = 32'h22222222; abort = 1;
    step;
    chk("ab_busy", busy, 0); chk("ab_s_ready0", s_ready, 0); chk("ab_arst_n", cpu_arst_n, 0);
    chk("ab_wen_lost", wen_ext, 0); chk("ab_done", done, 0);
    abort = 0; s_valid = 0;
    step;
    chk("ab_done_cnt", done_cnt, 2); chk("ab_idle", busy, 0);
    // restart after abort; dump address wraps past the top of the address space
    cmd(1, 1, 32'hFFFFFFFC, 2); s_valid = 1; s_data = 32'hDEADBEEF;
    step;
    start = 0;
    chk("re_s_ready", s_ready, 1);
    step;
    chk("re_wen", wen_ext, 1); chk("re_addr", addr_ext, 0); chk("re_data", wdata_ext, 32'hDEADBEEF); chk("re_s_ready0", s_ready, 0);
    s_valid = 0;
    step;
    chk("re_enable", cpu_enable, 1); chk("re_arst_n", cpu_arst_n, 1);
    step;
    chk("re_enable_off", cpu_enable, 0); chk("re_ren2", ren_ext_2, 1); chk("re_addr2_top", addr_ext_2, 32'hFFFFFFFC);
    m_ready = 1;
    step; step;
    chk("re_out0_valid", m_valid, 1); chk("re_out0_data", m_data, 32'hA5A5FFFC);
    step;
    chk("re_ren2_wrap", ren_ext_2, 1); chk("re_addr2_wrap", addr_ext_2, 32'h0);
    step; step;
    chk("re_out1_valid", m_valid, 1); chk("re_out1_data", m_data, 32'h5A5A0000);
    step;
    chk("re_done", done, 1);
    m_ready = 0;
    step;
    chk("re_done_cnt", done_cnt, 3); chk("re_idle", busy, 0);
    // asynchronous reset during RUN
    cmd(0, 5, 32'h80, 0);
    step;
    start = 0;
    chk("ar_enable", cpu_enable, 1); chk("ar_addr2_pre", addr_ext_2, 32'h80);
    step;
    chk("ar_enable2", cpu_enable, 1);
    #2 arst = 1;
    #1;
    chk("ar_enable_off", cpu_enable, 0); chk("ar_busy", busy, 0); chk("ar_arst_n", cpu_arst_n, 0);
    chk("ar_s_ready", s_ready, 0); chk("ar_m_valid", m_valid, 0); chk("ar_done", done, 0);
    chk("ar_wdata", wdata_ext, 0); chk("ar_addr2", addr_ext_2, 0); chk("ar_m_data", m_data, 0);
    @(posedge clk); #1 arst = 0;
    step;
    chk("ar_after_busy", busy, 0); chk("ar_done_cnt", done_cnt, 3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
